// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared types for the CPU memory-port arbiter: transaction phase and port owner.
// Kept separate so the future AXI bridge can reuse the same encodings.
package cpu_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/cpu_mem_arbiter.sv
// Serialises the instruction and data requesters onto one memory port,
// one transaction outstanding at a time, with data given fixed priority.
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                inst_req,
    input  logic                inst_wr,
    input  logic [1:0]          inst_size,
    input  logic [DATA_W/8-1:0] inst_wstrb,
    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic [DATA_W-1:0]   inst_wdata,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,

    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,

    output logic                m_req,
    output logic                m_wr,
    output logic [1:0]          m_size,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_addr_ok,
    input  logic                m_data_ok,
    input  logic [DATA_W-1:0]   m_rdata
);

    arb_state_e state_q, state_d;
    arb_owner_e owner_q, owner_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_INST;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Arbitration is shared by IDLE and the data-phase completion in WAIT,
    // which lets back-to-back requests skip the idle cycle.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (state_q == ST_IDLE || m_data_ok) begin
                    if (data_req) begin
                        owner_d = OWN_DATA;
                        state_d = ST_ADDR;
                    end else if (inst_req) begin
                        owner_d = OWN_INST;
                        state_d = ST_ADDR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ADDR: begin
                if (m_addr_ok) begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_INST;
            end
        endcase
    end

    always_comb begin
        m_req        = 1'b0;
        m_wr         = 1'b0;
        m_size       = '0;
        m_wstrb      = '0;
        m_addr       = '0;
        m_wdata      = '0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = '0;
        data_rdata   = '0;
        case (state_q)
            ST_ADDR: begin
                m_req = 1'b1;
                if (owner_q == OWN_DATA) begin
                    m_wr         = data_wr;
                    m_size       = data_size;
                    m_wstrb      = data_wstrb;
                    m_addr       = data_addr;
                    m_wdata      = data_wdata;
                    data_addr_ok = m_addr_ok;
                end else begin
                    m_wr         = inst_wr;
                    m_size       = inst_size;
                    m_wstrb      = inst_wstrb;
                    m_addr       = inst_addr;
                    m_wdata      = inst_wdata;
                    inst_addr_ok = m_addr_ok;
                end
            end
            ST_WAIT: begin
                if (owner_q == OWN_DATA) begin
                    data_data_ok = m_data_ok;
                    data_rdata   = m_data_ok ? m_rdata : '0;
                end else begin
                    inst_data_ok = m_data_ok;
                    inst_rdata   = m_data_ok ? m_rdata : '0;
                end
            end
            default: ;
        endcase
    end

endmodule
